teclado_cajero: RTL

- Keypad front end for the ATM controller. It sits directly upstream of the controller and drives its `digito`/`digito_stb` and `monto`/`monto_stb` inputs.
- It synchronizes and debounces the raw keypad press line and emits exactly one event per physical press.
- In PIN mode it forwards single digits. In amount mode it assembles a decimal amount, then delivers it when ENTER is pressed.

---
 rtl/teclado_cajero_if.sv | 24 ++
 rtl/teclado_cajero.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/teclado_cajero_if.sv
// teclado_cajero_if: keypad-side inputs and controller-side strobes of the ATM keypad front end
interface teclado_cajero_if #(
    parameter int MONTO_WIDTH = 32
);
    logic                   tecla_presionada;
    logic [3:0]             codigo_tecla;
    logic                   modo;
    logic [3:0]             digito;
    logic                   digito_stb;
    logic [MONTO_WIDTH-1:0] monto;
    logic                   monto_stb;
    logic                   cancelar;
    logic                   tecla_invalida;

    modport master (
        output tecla_presionada, codigo_tecla, modo,
        input  digito, digito_stb, monto, monto_stb, cancelar, tecla_invalida
    );

    modport slave (
        input  tecla_presionada, codigo_tecla, modo,
        output digito, digito_stb, monto, monto_stb, cancelar, tecla_invalida
    );
endinterface

// File: rtl/teclado_cajero.sv
// teclado_cajero: debounced keypad front end forwarding PIN digits and assembled decimal amounts
module teclado_cajero #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MONTO_WIDTH     = 32,
    parameter int MAX_DIGITOS     = 9
) (
    input logic clk,
    input logic reset,
    teclado_cajero_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NW = $clog2(MAX_DIGITOS + 1);
    localparam logic [CW-1:0] D_CNT   = CW'(DEBOUNCE_CYCLES);
    localparam logic [NW-1:0] MAX_CNT = NW'(MAX_DIGITOS);

    typedef enum logic [1:0] {LIBRE, CONTANDO_P, PRESIONADA, CONTANDO_L} estado_t;

    estado_t                estado_q, estado_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_sig;
    logic                   sync1_q, tp_s, armado_q;
    logic [1:0]             vld_q;
    logic                   evento_q, evento_d, llega;
    logic [3:0]             codigo_q;
    logic                   modo_q, cambio;
    logic [MONTO_WIDTH-1:0] acc_q, acc_d, acc_base, acc_x10, monto_q, monto_d;
    logic [NW-1:0]          conteo_q, conteo_d, cnt_base;
    logic [3:0]             digito_q, digito_d;
    logic                   dstb_q, dstb_d, mstb_q, mstb_d, canc_q, canc_d, inv_q, inv_d;
    logic                   es_dig;

    // Synchronizer, valid-sample tracking and arming: a key held through reset must be seen released first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            tp_s     <= 1'b0;
            vld_q    <= 2'b00;
            armado_q <= 1'b0;
        end else begin
            sync1_q  <= bus.tecla_presionada;
            tp_s     <= sync1_q;
            vld_q    <= {vld_q[0], 1'b1};
            armado_q <= armado_q | (vld_q[1] & ~tp_s);
        end
    end

    assign cnt_sig = cnt_q + CW'(1);
    assign llega   = cnt_sig == D_CNT;

    // Debounce next state; the counter is zero in LIBRE/PRESIONADA, so cnt_sig is 1 on entry to counting
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        evento_d = 1'b0;
        case (estado_q)
            LIBRE, CONTANDO_P: begin
                if (!tp_s || !armado_q) begin
                    estado_d = LIBRE;
                    cnt_d    = '0;
                end else begin
                    estado_d = llega ? PRESIONADA : CONTANDO_P;
                    cnt_d    = llega ? '0 : cnt_sig;
                    evento_d = llega;
                end
            end
            default: begin
                if (tp_s) begin
                    estado_d = PRESIONADA;
                    cnt_d    = '0;
                end else begin
                    estado_d = llega ? LIBRE : CONTANDO_L;
                    cnt_d    = llega ? '0 : cnt_sig;
                end
            end
        endcase
    end

    // Debounce state, registered event and key code captured on the event cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= LIBRE;
            cnt_q    <= '0;
            evento_q <= 1'b0;
            codigo_q <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            evento_q <= evento_d;
            codigo_q <= evento_d ? bus.codigo_tecla : codigo_q;
        end
    end

    assign cambio   = bus.modo != modo_q;
    assign acc_base = cambio ? '0 : acc_q;
    assign cnt_base = cambio ? '0 : conteo_q;
    assign acc_x10  = (acc_base << 3) + (acc_base << 1) + MONTO_WIDTH'(codigo_q);
    assign es_dig   = codigo_q <= 4'd9;

    // Event processing under the current modo, after any mode-change clear
    always_comb begin
        digito_d = digito_q;
        monto_d  = monto_q;
        acc_d    = acc_base;
        conteo_d = cnt_base;
        dstb_d   = 1'b0;
        mstb_d   = 1'b0;
        canc_d   = 1'b0;
        inv_d    = 1'b0;
        if (evento_q && !bus.modo) begin
            if (es_dig) begin
                digito_d = codigo_q;
                dstb_d   = 1'b1;
            end else if (codigo_q == 4'd12) begin
                canc_d = 1'b1;
            end else begin
                inv_d = 1'b1;
            end
        end else if (evento_q) begin
            if (es_dig) begin
                if (cnt_base == MAX_CNT) begin
                    inv_d = 1'b1;
                end else begin
                    acc_d    = acc_x10;
                    conteo_d = cnt_base + ((acc_base == '0 && codigo_q == 4'd0) ? NW'(0) : NW'(1));
                end
            end else if (codigo_q == 4'd10) begin
                if (cnt_base == '0) begin
                    inv_d = 1'b1;
                end else begin
                    monto_d  = acc_base;
                    mstb_d   = 1'b1;
                    acc_d    = '0;
                    conteo_d = '0;
                end
            end else if (codigo_q == 4'd11 || codigo_q == 4'd12) begin
                canc_d   = codigo_q == 4'd12;
                acc_d    = '0;
                conteo_d = '0;
            end else begin
                inv_d = 1'b1;
            end
        end
    end

    // Registered outputs, accumulator and mode history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            modo_q   <= 1'b0;
            acc_q    <= '0;
            conteo_q <= '0;
            digito_q <= '0;
            monto_q  <= '0;
            dstb_q   <= 1'b0;
            mstb_q   <= 1'b0;
            canc_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            modo_q   <= bus.modo;
            acc_q    <= acc_d;
            conteo_q <= conteo_d;
            digito_q <= digito_d;
            monto_q  <= monto_d;
            dstb_q   <= dstb_d;
            mstb_q   <= mstb_d;
            canc_q   <= canc_d;
            inv_q    <= inv_d;
        end
    end

    assign bus.digito         = digito_q;
    assign bus.digito_stb     = dstb_q;
    assign bus.monto          = monto_q;
    assign bus.monto_stb      = mstb_q;
    assign bus.cancelar       = canc_q;
    assign bus.tecla_invalida = inv_q;
endmodule
